// File: rtl/stream_pkg.sv
// Shared stream flag bit positions and arbiter state encoding.
// mflags = {again,first,last,vld}, sflags = {abt,bsy}.
package stream_pkg;

  localparam int MF_AGAIN = 3;
  localparam int MF_FIRST = 2;
  localparam int MF_LAST  = 1;
  localparam int MF_VLD   = 0;
  localparam int SF_ABT   = 1;
  localparam int SF_BSY   = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/stream_frame_arb_if.sv
// Bundle of the N upstream ports, the downstream port and arbiter status.
// slave = arbiter side, master = environment side.
interface stream_frame_arb_if #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int NB = 2
);

  logic [N*W-1:0] u_d;
  logic [N*4-1:0] u_mflags;
  logic [N*2-1:0] u_sflags;
  logic [W-1:0]   d_d;
  logic [3:0]     d_mflags;
  logic [1:0]     d_sflags;
  logic           grant_vld;
  logic [NB-1:0]  grant_id;
  logic           tmo_pulse;
  logic           proto_err;

  modport slave (
    input  u_d, u_mflags, d_sflags,
    output u_sflags, d_d, d_mflags,
    output grant_vld, grant_id,
    output tmo_pulse, proto_err
  );

  modport master (
    output u_d, u_mflags, d_sflags,
    input  u_sflags, d_d, d_mflags,
    input  grant_vld, grant_id,
    input  tmo_pulse, proto_err
  );

endinterface

// File: rtl/stream_frame_arb_rr_pick.sv
// Round-robin picker: first set req at or after ptr, wrapping modulo N.
// Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int NB = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [NB-1:0] ptr_i,
  output logic          any_o,
  output logic [NB-1:0] idx_o
);

  int   j;
  logic hit;

  always_comb begin
    hit   = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!hit && req_i[j]) begin
        hit   = 1'b1;
        idx_o = NB'(j);
      end
    end
    any_o = hit;
  end

endmodule

// File: rtl/stream_frame_arb.sv
// Frame-aware round-robin arbiter: N upstream streams onto one
// downstream stream, grant held from first beat until last/abort/timeout.
module stream_frame_arb
  import stream_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 4,
  parameter int NB  = 2,
  parameter int TMO = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_frame_arb_if.slave bus
);

  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TMO);
  localparam logic [TW-1:0] TMO_M1  = TW'((TMO > 0) ? TMO - 1 : 0);

  state_e          state_q, state_d;
  logic [NB-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NB-1:0]   gid_q, gid_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            beat_q, beat_d;
  logic            tmo_pulse_q, tmo_pulse_d;
  logic            err_q, err_d;

  logic [N-1:0]    req;
  logic [N-1:0]    bad;
  logic            any;
  logic [NB-1:0]   pick;
  logic [3:0]      g_mf;
  logic [W-1:0]    g_d;
  logic            lock;
  logic            acc;
  logic            abt;
  logic            tmo_hit;
  logic [NB-1:0]   nxt_ptr;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i] = bus.u_mflags[i*4 + MF_VLD] & bus.u_mflags[i*4 + MF_FIRST];
      bad[i] = bus.u_mflags[i*4 + MF_VLD] & ~bus.u_mflags[i*4 + MF_FIRST];
    end
  end

  rr_pick #(.N(N), .NB(NB)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .any_o (any),
    .idx_o (pick)
  );

  assign g_mf    = bus.u_mflags[int'(gid_q)*4 +: 4];
  assign g_d     = bus.u_d[int'(gid_q)*W +: W];
  assign lock    = (state_q == ST_LOCK);
  assign acc     = lock & g_mf[MF_VLD] & ~bus.d_sflags[SF_BSY];
  assign abt     = lock & bus.d_sflags[SF_ABT];
  assign nxt_ptr = (gid_q == NB'(N - 1)) ? '0 : gid_q + 1'b1;

  // Release on the cycle the idle count reaches TMO, so the grant
  // drops exactly TMO cycles after the granted requester went quiet.
  assign tmo_hit = (TMO > 0) && lock && !g_mf[MF_VLD] &&
                   (tmo_cnt_q == TMO_M1);

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    rr_ptr_d    = rr_ptr_q;
    tmo_cnt_d   = tmo_cnt_q;
    beat_d      = beat_q;
    tmo_pulse_d = 1'b0;
    err_d       = err_q | (~lock & (|bad));
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          gid_d     = pick;
          state_d   = ST_LOCK;
          tmo_cnt_d = '0;
          beat_d    = 1'b0;
        end
      end
      ST_LOCK: begin
        if (g_mf[MF_VLD]) begin
          tmo_cnt_d = '0;
        end else if (TMO > 0 && tmo_cnt_q != TMO_LIM) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (acc) begin
          beat_d = 1'b1;
          if (g_mf[MF_FIRST] && beat_q) err_d = 1'b1;
        end
        if ((acc && g_mf[MF_LAST]) || abt || tmo_hit) begin
          state_d  = ST_IDLE;
          rr_ptr_d = nxt_ptr;
        end
        tmo_pulse_d = tmo_hit & ~abt;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      tmo_cnt_q   <= '0;
      beat_q      <= 1'b0;
      tmo_pulse_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gid_q       <= gid_d;
      tmo_cnt_q   <= tmo_cnt_d;
      beat_q      <= beat_d;
      tmo_pulse_q <= tmo_pulse_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    bus.d_d      = lock ? g_d : '0;
    bus.d_mflags = lock ? g_mf : 4'b0000;
    for (int i = 0; i < N; i++) begin
      bus.u_sflags[i*2 +: 2] =
        (lock && gid_q == NB'(i)) ? bus.d_sflags : 2'b01;
    end
  end

  assign bus.grant_vld = lock;
  assign bus.grant_id  = gid_q;
  assign bus.tmo_pulse = tmo_pulse_q;
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_stream_frame_arb.sv
// Bench for stream_frame_arb: per-requester frame drivers, expected
// downstream beats queued by the directed tests, popped by a monitor.
module tb_stream_frame_arb;

  logic clk;
  logic rst_n;

  stream_frame_arb_if #(.W(32), .N(4), .NB(2)) bus ();

  stream_frame_arb #(.W(32), .N(4), .NB(2), .TMO(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  mf;
    logic [1:0]  id;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  int          nleft[4];
  int          len[4];
  int          b[4];
  int          fr[4];
  bit          hold[4];
  bit          nofirst[4];
  bit          allfirst[4];
  logic [31:0] base[4];
  logic [3:0]  dm;
  logic [1:0]  sf_t;
  logic        prev_last = 1'b0;
  exp_t        e_m;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drivers present the current beat after each rising edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (nleft[i] > 0 && !hold[i])
        dm = {1'b0, allfirst[i] || b[i] == 0, b[i] == len[i] - 1, 1'b1};
      else if (nofirst[i])
        dm = 4'b0001;
      else
        dm = 4'b0000;
      bus.u_mflags[i*4 +: 4] = dm;
      bus.u_d[i*32 +: 32] = base[i] + 32'(fr[i] << 8) + 32'(b[i]);
    end
  end

  // Drivers advance on handshake or drop the frame on abort.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (nleft[i] > 0 && !hold[i]) begin
          sf_t = bus.u_sflags[i*2 +: 2];
          if (sf_t[1]) begin
            b[i] = 0; fr[i]++; nleft[i]--;
          end else if (!sf_t[0]) begin
            b[i]++;
            if (b[i] == len[i]) begin
              b[i] = 0; fr[i]++; nleft[i]--;
            end
          end
        end
      end
    end
  end

  // Monitor: every accepted downstream beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.d_mflags[0] && !bus.d_sflags[0]) begin
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_beat: got d=%0h expected none", bus.d_d);
      end else begin
        e_m = q.pop_front();
        chk("beat_d", 64'(bus.d_d), 64'(e_m.d));
        chk("beat_mf", 64'(bus.d_mflags), 64'(e_m.mf));
        chk("beat_id", 64'(bus.grant_id), 64'(e_m.id));
        chk("bubble", 64'(prev_last), 64'd0);
      end
      prev_last = bus.d_mflags[1];
    end else begin
      prev_last = 1'b0;
    end
  end

  task automatic push(int i, int f, int bb, int ln, bit af);
    exp_t e;
    e.d  = base[i] + 32'(f << 8) + 32'(bb);
    e.mf = {1'b0, af || bb == 0, bb == ln - 1, 1'b1};
    e.id = 2'(i);
    q.push_back(e);
  endtask

  task automatic push_frame(int i, int f, int ln);
    for (int k = 0; k < ln; k++) push(i, f, k, ln, 1'b0);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_drv();
    for (int i = 0; i < 4; i++) begin
      nleft[i] = 0; len[i] = 1; b[i] = 0; fr[i] = 0;
      hold[i] = 0; nofirst[i] = 0; allfirst[i] = 0;
      base[i] = 32'(i) << 24;
    end
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_gvld"}, 64'(bus.grant_vld), 64'd0);
    chk({tag, "_gid"}, 64'(bus.grant_id), 64'd0);
    chk({tag, "_dmf"}, 64'(bus.d_mflags), 64'd0);
    chk({tag, "_dd"}, 64'(bus.d_d), 64'd0);
    chk({tag, "_usf"}, 64'(bus.u_sflags), 64'h55);
    chk({tag, "_tmo"}, 64'(bus.tmo_pulse), 64'd0);
    chk({tag, "_err"}, 64'(bus.proto_err), 64'd0);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    bus.d_sflags = 2'b00;
    #3;
    check_reset(tag);
    clear_drv();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic drain(string tag);
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      step();
    end
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_drv();
    do_reset("rst0");

    // single-beat frame from u0
    step();
    base[0] = 32'hA5; len[0] = 1; nleft[0] = 1;
    push_frame(0, 0, 1);
    smp(); chk("t1_latency", 64'(bus.grant_vld), 64'd0);
    step(); smp();
    chk("t1_gvld", 64'(bus.grant_vld), 64'd1);
    chk("t1_gid", 64'(bus.grant_id), 64'd0);
    chk("t1_dmf", 64'(bus.d_mflags), 64'h7);
    chk("t1_dd", 64'(bus.d_d), 64'hA5);
    step(); smp();
    chk("t1_idle", 64'(bus.grant_vld), 64'd0);
    chk("t1_dmf0", 64'(bus.d_mflags), 64'd0);

    // rr_ptr is 1: u1 wins over u0, then wrap to u0
    step();
    nleft[0] = 1; nleft[1] = 1;
    push_frame(1, 0, 1);
    push_frame(0, 1, 1);
    drain("t1b");

    // fairness: 3-beat frames from all requesters
    do_reset("rst2");
    step();
    for (int i = 0; i < 4; i++) begin
      len[i] = 3; nleft[i] = (i == 0) ? 2 : 1;
    end
    for (int i = 0; i < 4; i++) push_frame(i, 0, 3);
    push_frame(0, 1, 3);
    drain("t2");

    // backpressure mid-frame
    do_reset("rst3");
    step();
    len[2] = 4; nleft[2] = 1;
    push_frame(2, 0, 4);
    step();
    nleft[0] = 1;
    push_frame(0, 0, 1);
    step(2);
    bus.d_sflags = 2'b01;
    repeat (5) begin
      smp();
      chk("t3_usf", 64'(bus.u_sflags), 64'h55);
      chk("t3_dmf", 64'(bus.d_mflags), 64'h1);
      chk("t3_dd", 64'(bus.d_d), 64'h0200_0002);
      step();
    end
    bus.d_sflags = 2'b00;
    drain("t3");

    // abort on beat 2 of the u2 frame
    do_reset("rst4");
    step();
    len[2] = 4; nleft[2] = 1;
    push(2, 0, 0, 4, 1'b0);
    step();
    nleft[0] = 1; nleft[3] = 1;
    push_frame(3, 0, 1);
    push_frame(0, 0, 1);
    step();
    bus.d_sflags = 2'b11;
    smp();
    chk("t4_usf", 64'(bus.u_sflags), 64'h75);
    chk("t4_dmf", 64'(bus.d_mflags), 64'h1);
    step();
    bus.d_sflags = 2'b00;
    smp(); chk("t4_rel", 64'(bus.grant_vld), 64'd0);
    step(); smp();
    chk("t4_gvld", 64'(bus.grant_vld), 64'd1);
    chk("t4_gid", 64'(bus.grant_id), 64'd3);
    drain("t4");

    // timeout after u1 goes quiet
    do_reset("rst5");
    step();
    len[1] = 3; nleft[1] = 1;
    push(1, 0, 0, 3, 1'b0);
    step(2);
    hold[1] = 1;
    repeat (4) begin
      smp();
      chk("t5_hold", 64'(bus.grant_vld), 64'd1);
      chk("t5_nopulse", 64'(bus.tmo_pulse), 64'd0);
      chk("t5_noabt", 64'(bus.u_sflags[3]), 64'd0);
      step();
    end
    smp();
    chk("t5_rel", 64'(bus.grant_vld), 64'd0);
    chk("t5_pulse", 64'(bus.tmo_pulse), 64'd1);
    chk("t5_noabt2", 64'(bus.u_sflags[3]), 64'd0);
    step(); smp();
    chk("t5_pulse1", 64'(bus.tmo_pulse), 64'd0);
    hold[1] = 0; nleft[1] = 0; b[1] = 0;
    drain("t5");

    // repeated first inside a frame
    do_reset("rst6");
    step();
    len[0] = 2; nleft[0] = 1; allfirst[0] = 1;
    push(0, 0, 0, 2, 1'b1);
    push(0, 0, 1, 2, 1'b1);
    smp(); chk("t6_err0", 64'(bus.proto_err), 64'd0);
    step(); smp(); chk("t6_err1", 64'(bus.proto_err), 64'd0);
    step(); smp(); chk("t6_err2", 64'(bus.proto_err), 64'd0);
    step(); smp(); chk("t6_err3", 64'(bus.proto_err), 64'd1);
    allfirst[0] = 0;
    drain("t6");

    // vld without first while idle, then reset mid-frame
    do_reset("rst7");
    step();
    nofirst[3] = 1;
    smp(); chk("t7_err0", 64'(bus.proto_err), 64'd0);
    step(); smp();
    chk("t7_err1", 64'(bus.proto_err), 64'd1);
    chk("t7_nogrant", 64'(bus.grant_vld), 64'd0);
    step();
    nofirst[3] = 0;
    len[0] = 4; nleft[0] = 1;
    push(0, 0, 0, 4, 1'b0);
    push(0, 0, 1, 4, 1'b0);
    smp(); chk("t7_nogrant2", 64'(bus.grant_vld), 64'd0);
    step(); smp();
    chk("t7_gvld", 64'(bus.grant_vld), 64'd1);
    chk("t7_gid", 64'(bus.grant_id), 64'd0);
    step(2);
    do_reset("midrst");
    step(3); smp();
    chk("t7_noreplay", 64'(bus.grant_vld), 64'd0);
    drain("t7");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
